inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Instruction-stream producer for the decode stage: owns the PC, issues reads to the synchronous instruction BRAM, buffers returned words, and presents them with valid/ready.
- Decode consumes the stream; opcode_id and funct7_id are driven straight from the head entry into the control decoder.
- Branch redirects come back from the pipeline. On a redirect the block flushes its buffer and any in-flight read, then resumes fetching at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 14, instruction memory word-address width.
- DEPTH, 2, instruction buffer entries; legal values are 2 and 4.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- imem_en  output  1  read enable to the instruction BRAM.
- imem_addr  output  IMEM_AW  word address; equals pc[IMEM_AW+1:2].
- imem_rdata  input  32  read data; valid in the cycle after imem_en.
- inst_id  output  32  head instruction word.
- pc_id  output  32  PC of the head instruction.
- opcode_id  output  7  inst_id[6:0].
- funct7_id  output  7  inst_id[31:25].
- valid_id  output  1  head entry is valid.
- ready_id  input  1  decode accepts the head this cycle.
- redirect_valid  input  1  branch taken or redirect request.
- redirect_pc  input  32  redirect target; bits [1:0] are ignored and treated as 0.

Behaviour:
- Reset (async, rstn=0):
  - pc=RESET_PC, buffer empty (count=0), inflight=0, kill=0.
  - valid_id=0, imem_en=0; inst_id, pc_id, opcode_id and funct7_id all read 0.
  - Deassertion is sampled on a clk edge. The first issue occurs in the first cycle with rstn=1.
- Definitions: pop = valid_id & ready_id.
- Issue rule (per cycle, when no redirect):
  - imem_en=1 iff (count + inflight - pop) < DEPTH.
  - On issue: imem_addr comes from the current pc; pc <= pc + 4 (32-bit wrap, no flag); inflight <= 1, otherwise inflight <= 0.
- Return path:
  - When inflight=1 and kill=0, {imem_rdata, issued pc} is written at the buffer tail at the end of that cycle.
  - The issued PC is held in a register alongside inflight.
- Latency:
  - Issue in cycle t, data in t+1, valid_id=1 in t+2.
  - There is no bypass from imem_rdata to inst_id.
- Throughput: 1 instruction per cycle sustained while ready_id=1.
- Buffer:
  - FIFO with wrap-around read/write pointers.
  - Push and pop in the same cycle are both honoured.
  - Pop on empty cannot occur, since valid_id=0.
  - Push on full cannot occur by construction; assertion: count never exceeds DEPTH.
- Backpressure: with ready_id=0, head outputs hold stable and fetching stops once count+inflight=DEPTH.
- Redirect (redirect_valid=1 in cycle t):
  - imem_en=0 in t.
  - At the end of t: buffer cleared (count=0, pointers reset), pc <= {redirect_pc[31:2],2'b00}.
  - If inflight=1 at the end of t, kill <= 1, which discards that return in t+1. kill clears after one cycle.
  - Issue at the new PC in t+1, valid_id in t+3.
  - valid_id drops to 0 in t+1.
- Simultaneous events:
  - Redirect has priority over pop and over push; a pop in cycle t is treated as accepted by decode, but the buffer is cleared anyway.
  - Back-to-back redirects: the last one wins, and each redirect re-arms kill for any read issued in the preceding cycle.
- Reset mid-operation: everything returns to reset values immediately; any BRAM data arriving afterwards is ignored.
- Width rules:
  - The PC is full 32-bit; only [IMEM_AW+1:2] reaches memory.
  - Upper PC bits are carried to pc_id unchanged.

Test Plan:
- Reset release with BRAM holding 0x00000013 at word 0, 0x00100093 at word 1, ready_id=1:
  - imem_en rises in the first cycle after reset, with addresses 0,1,2,...
  - valid_id rises 2 cycles later.
  - pc_id sequence 0x0,0x4,0x8, one per cycle; opcode_id=7'b0010011.
- Backpressure:
  - Hold ready_id=0 for 6 cycles mid-stream: imem_en stops after count+inflight=DEPTH; inst_id/pc_id are stable.
  - On release, the pc_id sequence continues without a gap or duplicate.
- Redirect with a read in flight, redirect_pc=0x40 while fetching 0x10:
  - The word from 0x14 is never presented.
  - valid_id is 0 for 2 cycles, then pc_id=0x40, then 0x44.
- Redirect coincident with pop and push:
  - The buffer flushes; the next valid pc_id is the target.
  - count returns to 0; no stale entry appears.
- Back-to-back redirects to 0x100 then 0x200 in consecutive cycles: the first valid pc_id is 0x200, and 0x100 is never presented.
- rstn pulsed low for 1 cycle mid-stream: outputs return to 0 asynchronously, and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a synchronous instruction BRAM and buffers
// returned words in a small FIFO presented to decode with valid/ready.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 14,
    parameter int unsigned DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rstn,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        inst_id,
    output logic [31:0]        pc_id,
    output logic [6:0]         opcode_id,
    output logic [6:0]         funct7_id,
    output logic               valid_id,
    input  logic               ready_id,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc
);

    localparam int unsigned PW      = (DEPTH > 2) ? 2 : 1;
    localparam logic [3:0]  DEPTH_C = 4'(DEPTH);

    logic [31:0]   pc_q;
    logic [31:0]   inflight_pc_q;
    logic          inflight_q;
    logic          kill_q;
    logic [2:0]    count_q;
    logic [PW-1:0] rptr_q;
    logic [PW-1:0] wptr_q;
    logic [31:0]   buf_inst_q [DEPTH];
    logic [31:0]   buf_pc_q   [DEPTH];

    logic       pop;
    logic       push;
    logic       issue;
    logic [3:0] occupancy;

    always_comb begin
        valid_id  = (count_q != 3'd0);
        pop       = valid_id & ready_id;
        // Slots committed once this cycle settles: buffered + returning - leaving.
        occupancy = {1'b0, count_q} + {3'b000, inflight_q} - {3'b000, pop};
        issue     = rstn & ~redirect_valid & (occupancy < DEPTH_C);
        push      = inflight_q & ~kill_q & ~redirect_valid;
        imem_en   = issue;
        imem_addr = pc_q[IMEM_AW+1:2];
    end

    // Head is masked while empty so stale storage never leaks to decode.
    always_comb begin
        inst_id   = valid_id ? buf_inst_q[rptr_q] : 32'h0;
        pc_id     = valid_id ? buf_pc_q[rptr_q]   : 32'h0;
        opcode_id = inst_id[6:0];
        funct7_id = inst_id[31:25];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= 32'h0;
            inflight_q    <= 1'b0;
            kill_q        <= 1'b0;
            count_q       <= 3'd0;
            rptr_q        <= '0;
            wptr_q        <= '0;
        end else begin
            kill_q <= redirect_valid & inflight_q;
            if (redirect_valid) begin
                pc_q       <= redirect_pc & 32'hFFFF_FFFC;
                inflight_q <= 1'b0;
                count_q    <= 3'd0;
                rptr_q     <= '0;
                wptr_q     <= '0;
            end else begin
                inflight_q <= issue;
                if (issue) begin
                    pc_q          <= pc_q + 32'd4;
                    inflight_pc_q <= pc_q;
                end
                if (push) wptr_q <= wptr_q + 1'b1;
                if (pop) rptr_q <= rptr_q + 1'b1;
                count_q <= count_q + {2'b00, push} - {2'b00, pop};
            end
        end
    end

    // Storage needs no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst_q[wptr_q] <= imem_rdata;
            buf_pc_q[wptr_q]   <= inflight_pc_q;
        end
    end

    count_within_depth : assert property (@(posedge clk) disable iff (!rstn)
        count_q <= 3'(DEPTH));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit: a sequential-stream reference model feeds a
// scoreboard queue that a negedge monitor drains on every accepted instruction.
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned IMEM_AW  = 14;
    localparam int unsigned DEPTH    = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic               clk = 1'b0;
    logic               rstn;
    logic               imem_en;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [31:0]        inst_id;
    logic [31:0]        pc_id;
    logic [6:0]         opcode_id;
    logic [6:0]         funct7_id;
    logic               valid_id;
    logic               ready_id;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:(1<<IMEM_AW)-1];
    exp_t        exp_q [$];
    logic [31:0] next_pc;

    inst_fetch_unit #(
        .RESET_PC (RESET_PC),
        .IMEM_AW  (IMEM_AW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .inst_id        (inst_id),
        .pc_id          (pc_id),
        .opcode_id      (opcode_id),
        .funct7_id      (funct7_id),
        .valid_id       (valid_id),
        .ready_id       (ready_id),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // Synchronous BRAM: data one cycle after the enable.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return mem[pc[IMEM_AW+1:2]];
    endfunction

    // Reference: decode must see pc, pc+4, ... from the latest restart point.
    task automatic top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: next_pc, word: word_at(next_pc)});
            next_pc = next_pc + 32'd4;
        end
    endtask

    task automatic restart_stream(input logic [31:0] pc);
        exp_q.delete();
        next_pc = pc;
        top_up();
    endtask

    task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        if (rstn && redirect_valid) restart_stream(redirect_pc & 32'hFFFF_FFFC);
        top_up();
        #1;
        ready_id       = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    // Monitor
    int          since = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc;
    logic [31:0] prev_inst;
    int          stall_run = 0;
    int          stall_issues = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            check("reset_inst", inst_id, 32'h0);
            check("reset_pc", pc_id, 32'h0);
            check("reset_ctl", {16'h0, opcode_id, funct7_id, valid_id, imem_en}, 32'h0);
            since        = 0;
            prev_hold    = 1'b0;
            stall_run    = 0;
            stall_issues = 0;
        end else begin
            if (since < 4) since++;
            if (since == 1 || since == 2) check("bubble_valid", {31'b0, valid_id}, 32'd0);
            if (since == 3) check("first_valid", {31'b0, valid_id}, 32'd1);
            if (redirect_valid) check("redirect_no_issue", {31'b0, imem_en}, 32'd0);
            if (prev_hold) begin
                check("stall_pc", pc_id, prev_pc);
                check("stall_inst", inst_id, prev_inst);
            end
            if (valid_id && !ready_id && !redirect_valid) begin
                stall_run++;
                if (imem_en) stall_issues++;
                if (stall_run > DEPTH) check("stall_no_issue", {31'b0, imem_en}, 32'd0);
            end else begin
                if (stall_run > 0)
                    check("stall_issue_bound", {31'b0, stall_issues <= int'(DEPTH) - 1}, 32'd1);
                stall_run    = 0;
                stall_issues = 0;
            end
            if (valid_id && ready_id) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got pc %h required no instruction", pc_id);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", pc_id, e.pc);
                    check("pop_inst", inst_id, e.word);
                    check("pop_fields", {18'h0, opcode_id, funct7_id},
                          {18'h0, e.word[6:0], e.word[31:25]});
                end
            end
            if (redirect_valid) since = 0;
            prev_hold = valid_id && !ready_id && !redirect_valid;
            prev_pc   = pc_id;
            prev_inst = inst_id;
        end
    end

    initial begin
        for (int i = 0; i < (1 << IMEM_AW); i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        rstn           = 1'b0;
        ready_id       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        restart_stream(RESET_PC);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Streaming from reset, then a 6-cycle stall.
        repeat (20) cycle(1'b1, 1'b0, 32'h0);
        repeat (6)  cycle(1'b0, 1'b0, 32'h0);
        repeat (10) cycle(1'b1, 1'b0, 32'h0);

        // Restart at 0, then redirect to 0x40 right after 0x10 issues.
        cycle(1'b1, 1'b1, 32'h0);
        repeat (5)  cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h40);
        repeat (10) cycle(1'b1, 1'b0, 32'h0);

        // Redirect while streaming (pop and push both active).
        cycle(1'b1, 1'b1, 32'h300);
        repeat (10) cycle(1'b1, 1'b0, 32'h0);

        // Back-to-back redirects.
        cycle(1'b1, 1'b1, 32'h100);
        cycle(1'b1, 1'b1, 32'h200);
        repeat (10) cycle(1'b1, 1'b0, 32'h0);

        // Low bits ignored, PC wraps past 2^32.
        cycle(1'b1, 1'b1, 32'hFFFF_FFFB);
        repeat (10) cycle(1'b1, 1'b0, 32'h0);

        // One-cycle reset pulse mid-stream; outputs must clear without a clock edge.
        repeat (5) cycle(1'b1, 1'b0, 32'h0);
        rstn = 1'b0;
        restart_stream(RESET_PC);
        #1;
        check("async_reset_valid", {31'b0, valid_id}, 32'd0);
        check("async_reset_pc", pc_id, 32'h0);
        check("async_reset_en", {31'b0, imem_en}, 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        rstn = 1'b1;
        repeat (20) cycle(1'b1, 1'b0, 32'h0);

        // Randomized traffic.
        repeat (3000) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                  $urandom & 32'hFFFF_FFFF);
        end
        repeat (5) cycle(1'b1, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
